// File: rtl/os_rx_qualifier_if.sv
// rtl/os_rx_qualifier_if.sv - lane ordered-set qualifier bundle; err_cnt present only with OS_RX_ERRCNT_EN
interface os_rx_qualifier_if;
  logic       enable;
  logic       single_lane;
  logic [3:0] d_sel;
  logic [3:0] os_in_l0;
  logic [3:0] os_in_l1;
  logic       os_done;
  logic       os_timeout;
  logic       busy;
  logic [3:0] cnt_l0;
  logic [3:0] cnt_l1;
`ifdef OS_RX_ERRCNT_EN
  logic [7:0] err_cnt;

  modport master (
    output enable, single_lane, d_sel, os_in_l0, os_in_l1,
    input  os_done, os_timeout, busy, cnt_l0, cnt_l1, err_cnt
  );
  modport slave (
    input  enable, single_lane, d_sel, os_in_l0, os_in_l1,
    output os_done, os_timeout, busy, cnt_l0, cnt_l1, err_cnt
  );
`else
  modport master (
    output enable, single_lane, d_sel, os_in_l0, os_in_l1,
    input  os_done, os_timeout, busy, cnt_l0, cnt_l1
  );
  modport slave (
    input  enable, single_lane, d_sel, os_in_l0, os_in_l1,
    output os_done, os_timeout, busy, cnt_l0, cnt_l1
  );
`endif
endinterface

// File: rtl/os_rx_qualifier.sv
// rtl/os_rx_qualifier.sv - qualifies per-lane ordered sets for training; OS_RX_ERRCNT_EN adds err_cnt
module os_rx_qualifier #(
  parameter int REQ_COUNT   = 2,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic           clk,
  input logic           rst,
  os_rx_qualifier_if.slave q
);
  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

  localparam logic [3:0]           REQ     = 4'(REQ_COUNT);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  state_t               state, state_d;
  logic [3:0]           sel_q, sel_d;
  logic [3:0]           cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [TIMEOUT_W-1:0] to_q, to_d;
  logic                 done_q, done_d, timeout_q, timeout_d, busy_q;
  logic                 sel_ok, done_cond;

  // Codes 9..F are "nothing seen" and leave the run intact.
  function automatic logic [3:0] next_cnt(input logic [3:0] cnt, input logic [3:0] code,
                                          input logic [3:0] sel);
    if (code == sel)       return (cnt >= REQ) ? REQ : cnt + 4'd1;
    else if (code <= 4'h8) return 4'd0;
    else                   return cnt;
  endfunction

  always_comb begin
    state_d   = state;
    sel_d     = sel_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    to_d      = to_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    sel_ok    = (q.d_sel <= 4'h7);
    done_cond = (cnt0_q >= REQ) && (q.single_lane || (cnt1_q >= REQ));

    if (!q.enable) begin
      state_d = IDLE;
      cnt0_d  = 4'd0;
      cnt1_d  = 4'd0;
      to_d    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_ok) begin
            state_d = ARMED;
            sel_d   = q.d_sel;
            cnt0_d  = 4'd0;
            cnt1_d  = 4'd0;
            to_d    = '0;
          end
        end
        ARMED: begin
          if (q.d_sel != sel_q) begin
            state_d = sel_ok ? ARMED : IDLE;
            sel_d   = sel_ok ? q.d_sel : sel_q;
            cnt0_d  = 4'd0;
            cnt1_d  = 4'd0;
            to_d    = '0;
          end else begin
            cnt0_d = next_cnt(cnt0_q, q.os_in_l0, sel_q);
            if (!q.single_lane) cnt1_d = next_cnt(cnt1_q, q.os_in_l1, sel_q);
            // Done is judged on the counts already registered, so it beats a same-cycle timeout.
            if (done_cond) begin
              done_d  = 1'b1;
              state_d = HOLD;
            end else if (to_q == TO_LAST) begin
              timeout_d = 1'b1;
              state_d   = HOLD;
            end else begin
              to_d = to_q + TIMEOUT_W'(1);
            end
          end
        end
        HOLD: begin
          if (!sel_ok) begin
            state_d = IDLE;
          end else if (q.d_sel != sel_q) begin
            state_d = ARMED;
            sel_d   = q.d_sel;
            cnt0_d  = 4'd0;
            cnt1_d  = 4'd0;
            to_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel_q     <= 4'd0;
      cnt0_q    <= 4'd0;
      cnt1_q    <= 4'd0;
      to_q      <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_d;
      sel_q     <= sel_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      to_q      <= to_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d == ARMED);
    end
  end

  assign q.os_done    = done_q;
  assign q.os_timeout = timeout_q;
  assign q.busy       = busy_q;
  assign q.cnt_l0     = cnt0_q;
  assign q.cnt_l1     = cnt1_q;

`ifdef OS_RX_ERRCNT_EN
  logic [7:0] err_q;
  logic [8:0] err_sum;
  logic       counting, mis0, mis1, arm_evt;

  always_comb begin
    counting = q.enable && (state == ARMED) && (q.d_sel == sel_q);
    mis0     = counting && (q.os_in_l0 != sel_q) && (q.os_in_l0 <= 4'h8);
    mis1     = counting && !q.single_lane && (q.os_in_l1 != sel_q) && (q.os_in_l1 <= 4'h8);
    arm_evt  = (state_d == ARMED) && ((state != ARMED) || (q.d_sel != sel_q));
    err_sum  = {1'b0, err_q} + 9'(mis0) + 9'(mis1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 8'd0;
    else if (arm_evt) err_q <= 8'd0;
    else              err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign q.err_cnt = err_q;
`endif
endmodule

// File: tb/tb_os_rx_qualifier.sv
// tb/tb_os_rx_qualifier.sv - self-checking bench for os_rx_qualifier; err_cnt checks under OS_RX_ERRCNT_EN
module tb_os_rx_qualifier;
  localparam int REQ = 2;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  os_rx_qualifier_if qif();

  os_rx_qualifier #(.REQ_COUNT(REQ), .TIMEOUT_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .rst(rst),
    .q  (qif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=armed 2=hold; runs are unbounded match streaks,
  // age is the number of armed cycles since arming.
  int m_mode, m_sel, run0, run1, age, errs;
  bit e_done, e_to;

  task automatic model_reset();
    m_mode = 0; m_sel = 0; run0 = 0; run1 = 0; age = 0; errs = 0;
    e_done = 0; e_to = 0;
  endtask

  task automatic model_arm(input int d);
    m_mode = 1; m_sel = d; run0 = 0; run1 = 0; age = 0; errs = 0;
  endtask

  function automatic int lane_next(input int run, input int code, input int sel);
    if (code == sel) return run + 1;
    if (code <= 8)   return 0;
    return run;
  endfunction

  function automatic int is_mis(input int code, input int sel);
    return (code != sel && code <= 8) ? 1 : 0;
  endfunction

  task automatic model_step();
    int d, c0, c1;
    bit met;
    d = int'(qif.d_sel); c0 = int'(qif.os_in_l0); c1 = int'(qif.os_in_l1);
    e_done = 0; e_to = 0;
    if (!qif.enable) begin
      m_mode = 0; run0 = 0; run1 = 0;
    end else if (m_mode == 0) begin
      if (d <= 7) model_arm(d);
    end else if (m_mode == 1) begin
      if (d != m_sel) begin
        if (d <= 7) model_arm(d);
        else begin m_mode = 0; run0 = 0; run1 = 0; end
      end else begin
        met = (run0 >= REQ) && (qif.single_lane || run1 >= REQ);
        run0 = lane_next(run0, c0, m_sel);
        errs += is_mis(c0, m_sel);
        if (!qif.single_lane) begin
          run1 = lane_next(run1, c1, m_sel);
          errs += is_mis(c1, m_sel);
        end
        age++;
        if (met) begin e_done = 1; m_mode = 2; end
        else if (age == TO) begin e_to = 1; m_mode = 2; end
      end
    end else begin
      if (d > 7) m_mode = 0;
      else if (d != m_sel) model_arm(d);
    end
  endtask

  task automatic check_model();
    check("m_done", qif.os_done, e_done);
    check("m_timeout", qif.os_timeout, e_to);
    check("m_busy", qif.busy, (m_mode == 1));
    check("m_cnt_l0", qif.cnt_l0, (run0 > REQ) ? REQ : run0);
    check("m_cnt_l1", qif.cnt_l1, (run1 > REQ) ? REQ : run1);
    check("m_excl", qif.os_done & qif.os_timeout, 0);
`ifdef OS_RX_ERRCNT_EN
    check("m_err_cnt", qif.err_cnt, (errs > 255) ? 255 : errs);
`endif
  endtask

  task automatic cycle(input bit en, input bit sl, input logic [3:0] d,
                       input logic [3:0] c0, input logic [3:0] c1);
    qif.enable = en; qif.single_lane = sl; qif.d_sel = d;
    qif.os_in_l0 = c0; qif.os_in_l1 = c1;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit         en, sl;
    logic [3:0] d, c0, c1;
    bit         x_done, x_to, x_busy;
    logic [3:0] x_c0, x_c1;
  } vec_t;

  function automatic vec_t mk(input bit en, input bit sl, input logic [3:0] d,
                              input logic [3:0] c0, input logic [3:0] c1,
                              input bit xd, input bit xt, input bit xb,
                              input logic [3:0] x0, input logic [3:0] x1);
    vec_t v;
    v.en = en; v.sl = sl; v.d = d; v.c0 = c0; v.c1 = c1;
    v.x_done = xd; v.x_to = xt; v.x_busy = xb; v.x_c0 = x0; v.x_c1 = x1;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int tpos;
    bit dseen;
    logic [3:0] rd;
    bit ren, rsl;
    int r;

    tbl[0]  = mk(1, 0, 4'h2, 4'h9, 4'h9, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 4'h2, 4'h2, 4'h2, 0, 0, 1, 1, 1);
    tbl[2]  = mk(1, 0, 4'h2, 4'h2, 4'h2, 0, 0, 1, 2, 2);
    tbl[3]  = mk(1, 0, 4'h2, 4'h9, 4'h9, 1, 0, 0, 2, 2);
    tbl[4]  = mk(1, 0, 4'h2, 4'h9, 4'h9, 0, 0, 0, 2, 2);
    tbl[5]  = mk(1, 0, 4'h3, 4'h9, 4'h9, 0, 0, 1, 0, 0);
    tbl[6]  = mk(1, 0, 4'h3, 4'h3, 4'h3, 0, 0, 1, 1, 1);
    tbl[7]  = mk(1, 0, 4'h3, 4'h3, 4'h0, 0, 0, 1, 2, 0);
    tbl[8]  = mk(1, 0, 4'h3, 4'h9, 4'h3, 0, 0, 1, 2, 1);
    tbl[9]  = mk(1, 0, 4'h3, 4'h9, 4'h3, 0, 0, 1, 2, 2);
    tbl[10] = mk(1, 0, 4'h3, 4'h9, 4'h9, 1, 0, 0, 2, 2);
    tbl[11] = mk(1, 1, 4'h5, 4'h9, 4'h9, 0, 0, 1, 0, 0);
    tbl[12] = mk(1, 1, 4'h5, 4'h5, 4'h9, 0, 0, 1, 1, 0);
    tbl[13] = mk(1, 1, 4'h5, 4'h5, 4'h9, 0, 0, 1, 2, 0);
    tbl[14] = mk(1, 1, 4'h5, 4'h9, 4'h9, 1, 0, 0, 2, 0);
    tbl[15] = mk(0, 0, 4'h5, 4'h9, 4'h9, 0, 0, 0, 0, 0);

    qif.enable = 0; qif.single_lane = 0; qif.d_sel = 4'h9;
    qif.os_in_l0 = 4'h9; qif.os_in_l1 = 4'h9;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_done", qif.os_done, 0);
    check("rst_timeout", qif.os_timeout, 0);
    check("rst_busy", qif.busy, 0);
    check("rst_cnt_l0", qif.cnt_l0, 0);
    check("rst_cnt_l1", qif.cnt_l1, 0);
    rst = 1;

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].en, tbl[i].sl, tbl[i].d, tbl[i].c0, tbl[i].c1);
      check($sformatf("tbl%0d_done", i), qif.os_done, tbl[i].x_done);
      check($sformatf("tbl%0d_timeout", i), qif.os_timeout, tbl[i].x_to);
      check($sformatf("tbl%0d_busy", i), qif.busy, tbl[i].x_busy);
      check($sformatf("tbl%0d_cnt_l0", i), qif.cnt_l0, tbl[i].x_c0);
      check($sformatf("tbl%0d_cnt_l1", i), qif.cnt_l1, tbl[i].x_c1);
`ifdef OS_RX_ERRCNT_EN
      if (i == 10) check("tbl10_err_cnt", qif.err_cnt, 1);
`endif
    end

    // Timeout with nothing arriving.
    cycle(1, 0, 4'h4, 4'h9, 4'h9);
    tpos = -1; dseen = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1, 0, 4'h4, 4'h9, 4'h9);
      if (qif.os_timeout && tpos < 0) tpos = i;
      if (qif.os_done) dseen = 1;
    end
    check("t3_timeout_pos", tpos, TO);
    check("t3_no_done", dseen, 0);
    cycle(0, 0, 4'h9, 4'h9, 4'h9);

    // Re-arm on d_sel change mid-count, then enable drop.
    cycle(1, 0, 4'h6, 4'h9, 4'h9);
    cycle(1, 0, 4'h6, 4'h6, 4'h9);
    check("t5_cnt_l0_mid", qif.cnt_l0, 1);
    cycle(1, 0, 4'h7, 4'h7, 4'h7);
    check("t5_rearm_cnt_l0", qif.cnt_l0, 0);
    check("t5_rearm_cnt_l1", qif.cnt_l1, 0);
    check("t5_rearm_busy", qif.busy, 1);
    cycle(1, 0, 4'h7, 4'h7, 4'h7);
    check("t5_count_after", qif.cnt_l0, 1);
    cycle(0, 0, 4'h7, 4'h7, 4'h7);
    check("t5_dis_busy", qif.busy, 0);
    check("t5_dis_done", qif.os_done, 0);
    check("t5_dis_timeout", qif.os_timeout, 0);
    check("t5_dis_cnt_l0", qif.cnt_l0, 0);

    // Done and timeout land on the same cycle.
    cycle(1, 0, 4'h5, 4'h9, 4'h9);
    repeat (5) cycle(1, 0, 4'h5, 4'h9, 4'h9);
    repeat (2) cycle(1, 0, 4'h5, 4'h5, 4'h5);
    cycle(1, 0, 4'h5, 4'h9, 4'h9);
    check("coll_done", qif.os_done, 1);
    check("coll_timeout", qif.os_timeout, 0);
    cycle(0, 0, 4'h9, 4'h9, 4'h9);

    // Asynchronous reset in the middle of ARMED.
    cycle(1, 0, 4'h2, 4'h9, 4'h9);
    cycle(1, 0, 4'h2, 4'h2, 4'h2);
    #2 rst = 0;
    #1;
    check("arst_busy", qif.busy, 0);
    check("arst_cnt_l0", qif.cnt_l0, 0);
    check("arst_cnt_l1", qif.cnt_l1, 0);
    check("arst_done", qif.os_done, 0);
    check("arst_timeout", qif.os_timeout, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    cycle(1, 0, 4'h2, 4'h2, 4'h2);
    check("arst_rearm_busy", qif.busy, 1);
    check("arst_rearm_cnt", qif.cnt_l0, 0);

    // Randomized traffic against the model.
    rd = 4'h3; rsl = 0;
    for (int i = 0; i < 4000; i++) begin
      ren = ($urandom_range(99) < 97);
      if ($urandom_range(99) < 4) rd = 4'($urandom_range(9));
      if ($urandom_range(99) < 1) rsl = ~rsl;
      r = $urandom_range(3);
      qif.os_in_l0 = (r < 2) ? rd : (r == 2) ? 4'($urandom_range(8)) : 4'($urandom_range(15, 9));
      r = $urandom_range(3);
      cycle(ren, rsl, rd, qif.os_in_l0,
            (r < 2) ? rd : (r == 2) ? 4'($urandom_range(8)) : 4'($urandom_range(15, 9)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
